// File: rtl/arb_mux.sv
// Arbitrating N:1 multiplexer with a single-register output stage.
// Supports fixed-select and round-robin channel selection with valid/ready handshakes.
module arb_mux #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [SELW-1:0]      out_ch_q, out_ch_d;
  logic [SELW-1:0]      ptr_q, ptr_d;

  logic                 load;
  logic                 cand_ok;
  logic [SELW-1:0]      cand_idx;
  logic [WIDTH-1:0]     cand_data;
  logic [2*NCH-1:0]     dbl_sh;
  logic [NCH-1:0]       rot;
  logic                 rr_found;
  int                   rr_off;
  int                   rr_idx;
  logic                 xfer_in;

  // Candidate selection: fixed select or round-robin search starting after ptr.
  always_comb begin
    load      = ~out_valid_q | out_ready;
    cand_ok   = 1'b0;
    cand_idx  = '0;
    cand_data = '0;
    dbl_sh    = '0;
    rot       = '0;
    rr_found  = 1'b0;
    rr_off    = 0;
    rr_idx    = 0;
    if (!mode) begin
      // Out-of-range sel matches no channel, so it never grants.
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          cand_ok  = 1'b1;
          cand_idx = SELW'(i);
        end
      end
    end else begin
      // Rotating a doubled copy puts channel ptr+1 at bit 0, ptr itself last.
      dbl_sh = {in_valid, in_valid} >> (int'(ptr_q) + 1);
      rot    = dbl_sh[NCH-1:0];
      for (int k = 0; k < NCH; k++) begin
        if (!rr_found && rot[k]) begin
          rr_found = 1'b1;
          rr_off   = k;
        end
      end
      rr_idx = int'(ptr_q) + 1 + rr_off;
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      cand_ok  = rr_found;
      cand_idx = SELW'(rr_idx);
    end
    for (int i = 0; i < NCH; i++) begin
      if (cand_idx == SELW'(i)) cand_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load && cand_ok) in_ready = NCH'(1) << cand_idx;
    xfer_in = |in_ready;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_data_d  = cand_data;
      out_ch_d    = cand_idx;
      out_valid_d = 1'b1;
      if (mode) ptr_d = cand_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage; ptr resets to the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed vectors, expected output words queued at grant time
// and popped by an independent monitor whenever the DUT delivers a word.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic        mode3;
  logic [1:0]  sel3;
  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_ch3;

  int checks = 0;
  int failures = 0;

  logic [3:0] chdat [4] = '{4'h3, 4'h7, 4'hA, 4'hD};
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(4), .NCH(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  arb_mux #(.WIDTH(4), .NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One cycle: check both in_ready vectors at the negedge, queue the granted word.
  task automatic tick(input string nm, input logic [3:0] exp_rdy, input logic [2:0] exp_rdy3);
    logic [1:0] ch;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
    chk({nm, "_rdy3"}, 32'(in_ready3), 32'(exp_rdy3));
    if (exp_rdy != 4'b0000) begin
      ch = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) ch = 2'(i);
      exp_q.push_back({ch, chdat[ch]});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every delivered word must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected", {26'd0, out_ch, out_data}, 32'h3F);
      end else begin
        chk("mon_word", {26'd0, out_ch, out_data}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {chdat[3], chdat[2], chdat[1], chdat[0]};
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
    in_data3 = {4'h9, 4'h5, 4'h1};
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ch", 32'(out_ch), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
    tick("fix", 4'b0100, 3'b000);
    chk("fix_valid", 32'(out_valid), 32'h1);
    chk("fix_data", 32'(out_data), 32'hA);
    chk("fix_ch", 32'(out_ch), 32'h2);
    in_valid = 4'b0000;
    tick("fix_drain", 4'b0000, 3'b000);
    chk("fix_drained", 32'(out_valid), 32'h0);

    // Round-robin from reset pointer: 0,1,2,3,0 back to back
    mode = 1'b1; in_valid = 4'b1111;
    tick("rr0", 4'b0001, 3'b000);
    tick("rr1", 4'b0010, 3'b000);
    chk("rr_cont1", 32'(out_valid), 32'h1);
    tick("rr2", 4'b0100, 3'b000);
    chk("rr_cont2", 32'(out_valid), 32'h1);
    tick("rr3", 4'b1000, 3'b000);
    chk("rr_cont3", 32'(out_valid), 32'h1);
    tick("rr4", 4'b0001, 3'b000);
    chk("rr_cont4", 32'(out_valid), 32'h1);

    // Skipping: set ptr=1, then only channels 1 and 3 valid
    in_valid = 4'b0010;
    tick("skp_set", 4'b0010, 3'b000);
    in_valid = 4'b1010;
    tick("skp_a", 4'b1000, 3'b000);
    tick("skp_b", 4'b0010, 3'b000);
    tick("skp_c", 4'b1000, 3'b000);

    // Backpressure holds channel 3's word, then release loads channel 0 same edge
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick("bp", 4'b0000, 3'b000);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data", 32'(out_data), 32'hD);
      chk("bp_ch", 32'(out_ch), 32'h3);
    end
    out_ready = 1'b1;
    tick("bp_rel", 4'b0001, 3'b000);
    chk("bp_new_ch", 32'(out_ch), 32'h0);
    chk("bp_new_valid", 32'(out_valid), 32'h1);
    in_valid = 4'b0000;
    tick("bp_drain", 4'b0000, 3'b000);

    // Invalid fixed select: selected channel not valid
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1011;
    tick("inv_load", 4'b0001, 3'b000);
    sel = 2'd2;
    tick("inv_sel", 4'b0000, 3'b000);
    chk("inv_drained", 32'(out_valid), 32'h0);

    // NCH=3 instance: out-of-range sel never grants, round-robin wraps 2 -> 0
    in_valid = 4'b0000;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    tick("n3_oor", 4'b0000, 3'b000);
    chk("n3_oor_valid", 32'(out_valid3), 32'h0);
    sel3 = 2'd1;
    tick("n3_sel1", 4'b0000, 3'b010);
    chk("n3_sel1_ch", 32'(out_ch3), 32'h1);
    chk("n3_sel1_data", 32'(out_data3), 32'h5);
    mode3 = 1'b1;
    tick("n3_rr0", 4'b0000, 3'b001);
    tick("n3_rr1", 4'b0000, 3'b010);
    tick("n3_rr2", 4'b0000, 3'b100);
    tick("n3_rr3", 4'b0000, 3'b001);
    in_valid3 = 3'b000;

    // Mid-operation reset discards a held word
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick("mr_load", 4'b0010, 3'b000);
    out_ready = 1'b0; rst = 1'b1;
    tick("mr_rst", 4'b0000, 3'b000);
    void'(exp_q.pop_back());
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_data", 32'(out_data), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    tick("mr_next", 4'b0001, 3'b000);
    in_valid = 4'b0000;
    tick("mr_drain", 4'b0000, 3'b000);
    chk("end_valid", 32'(out_valid), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width per channel in bits (1..64).
REQ-002 The block SHALL have parameter NCH, default 4, giving the number of input channels (2..16).
REQ-003 The block SHALL have derived parameter SELW, default $clog2(NCH), giving the width of channel indices.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  selection mode: 0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SELW  channel index used in fixed mode.
REQ-008 in_data  input  NCH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel valid.
REQ-010 in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an undelivered word.
REQ-013 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-014 out_ch  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 Transfers SHALL occur on a rising edge where valid and ready are both high, on each side independently.
REQ-016 The output stage SHALL be a single register; load = ~out_valid | out_ready.
REQ-017 Fixed mode: candidate = sel when sel < NCH and in_valid[sel]=1; else no candidate (sel >= NCH never grants).
REQ-018 Round-robin mode: candidate = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... modulo NCH, ending at ptr itself.
REQ-019 in_ready SHALL be one-hot on the candidate when load=1 and a candidate exists; otherwise all zero.
REQ-020 in_ready SHALL be combinational from in_valid, mode, sel, ptr, out_valid, out_ready; in_valid SHALL NOT depend on in_ready.
REQ-021 On an input transfer: out_data <= candidate data, out_ch <= candidate index, out_valid <= 1; latency is one cycle from acceptance to out_valid.
REQ-022 On an output transfer with no input transfer, out_valid SHALL go to 0; out_data and out_ch SHALL hold.
REQ-023 Simultaneous output and input transfer SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-024 When out_valid=1 and out_ready=0, out_data, out_ch, and out_valid SHALL hold, and in_ready SHALL be all zero.
REQ-025 Internal pointer ptr (SELW bits) SHALL update to the granted index only on an input transfer in round-robin mode; it holds in fixed mode.
REQ-026 A mode or sel change SHALL take effect in the same cycle's grant decision, with no state flush.
REQ-027 For non-power-of-two NCH, ptr increments SHALL wrap from NCH-1 to 0.

Reset
REQ-028 While rst=1 at a rising edge: out_valid <= 0, out_data <= 0, out_ch <= 0, ptr <= NCH-1 (channel 0 has first priority).
REQ-029 in_ready SHALL be all zero in any cycle where rst=1, regardless of other inputs.
REQ-030 Reset asserted mid-operation SHALL discard any held output word; no transfer SHALL be reported on that edge.

Verification (WIDTH=4, NCH=4)
REQ-031 The bench SHALL cover fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data channel 2 = 4'hA, out_ready=1 -> in_ready=4'b0100, next cycle out_data=4'hA, out_ch=2, out_valid=1.
REQ-032 The bench SHALL cover round-robin: mode=1 after reset, all valid, out_ready=1 for 5 cycles -> grants 0,1,2,3,0 on consecutive cycles; out_valid continuous.
REQ-033 The bench SHALL cover round-robin skipping: in_valid=4'b1010, ptr=1 -> grant 3, then grant 1, then grant 3.
REQ-034 The bench SHALL cover backpressure: word held with out_ready=0 for 3 cycles -> out_data/out_ch stable, in_ready=0; out_ready=1 -> delivered, and a new word loads the same edge.
REQ-035 The bench SHALL cover an invalid select: mode=0, sel=2 with in_valid[2]=0, or sel out of range (NCH=3, sel=3) -> in_ready=0, out_valid falls after drain.
REQ-036 The bench SHALL cover mid-operation reset: rst=1 for 1 cycle while out_valid=1, out_ready=0 -> out_valid=0, out_data=0; next round-robin grant is channel 0.
